// File: rtl/legv8_mc_ctrl_if.sv
// ---------------------------------------------------------------------------
// legv8_mc_ctrl_if : opcode/handshake inputs and control outputs of the sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface legv8_mc_ctrl_if #(
  parameter int CNTW = 16
);
  logic [10:0]     opcode;
  logic            mem_ready;
  logic            pc_write;
  logic            ir_write;
  logic            branch;
  logic            uncondbranch;
  logic            mem_read;
  logic            mem_write;
  logic            reg_write;
  logic            reg2loc;
  logic            alu_src;
  logic            mem2reg;
  logic [1:0]      aluop;
  logic [2:0]      state;
  logic            illegal;
  logic            err;
  logic [CNTW-1:0] instr_count;

  modport master (
    output opcode, mem_ready,
    input  pc_write, ir_write, branch, uncondbranch, mem_read, mem_write,
           reg_write, reg2loc, alu_src, mem2reg, aluop, state, illegal, err,
           instr_count
  );

  modport slave (
    input  opcode, mem_ready,
    output pc_write, ir_write, branch, uncondbranch, mem_read, mem_write,
           reg_write, reg2loc, alu_src, mem2reg, aluop, state, illegal, err,
           instr_count
  );
endinterface

`default_nettype wire

// File: rtl/legv8_mc_ctrl.sv
// ---------------------------------------------------------------------------
// legv8_mc_ctrl : multi-cycle LEGv8 control sequencer with memory-ready timeout
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module legv8_mc_ctrl #(
  parameter int CNTW        = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  legv8_mc_ctrl_if.slave       bus
);

  localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_R    = 3'd1,
    C_LDUR = 3'd2,
    C_STUR = 3'd3,
    C_CBZ  = 3'd4,
    C_B    = 3'd5
  } class_t;

  state_t          state_q, state_d;
  class_t          cls_q, cls_dec;
  logic [WW-1:0]   wait_q, wait_d;
  logic            err_q;
  logic [CNTW-1:0] cnt_q;
  logic            retire;

  always_comb begin
    cls_dec = C_NONE;
    if (bus.opcode[10:5] == 6'b000101)          cls_dec = C_B;
    else if (bus.opcode[10:3] == 8'b10110100)   cls_dec = C_CBZ;
    else if (bus.opcode == 11'b11111000010)     cls_dec = C_LDUR;
    else if (bus.opcode == 11'b11111000000)     cls_dec = C_STUR;
    else if (bus.opcode == 11'b10001011000 || bus.opcode == 11'b11001011000 ||
             bus.opcode == 11'b10001010000 || bus.opcode == 11'b10101010000)
      cls_dec = C_R;
  end

  always_comb begin
    state_d          = state_q;
    wait_d           = '0;
    retire           = 1'b0;
    bus.pc_write     = 1'b0;
    bus.ir_write     = 1'b0;
    bus.branch       = 1'b0;
    bus.uncondbranch = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.reg_write    = 1'b0;
    bus.reg2loc      = 1'b0;
    bus.alu_src      = 1'b0;
    bus.mem2reg      = 1'b0;
    bus.aluop        = 2'b00;
    bus.illegal      = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        bus.reg2loc = (cls_dec == C_STUR) || (cls_dec == C_CBZ);
        if (cls_dec == C_NONE) begin
          bus.illegal = 1'b1;
          state_d     = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_R: begin
            bus.aluop = 2'b10;
            state_d   = S_WB;
          end
          C_LDUR, C_STUR: begin
            bus.alu_src = 1'b1;
            state_d     = S_MEM;
          end
          C_CBZ: begin
            bus.aluop    = 2'b01;
            bus.reg2loc  = 1'b1;
            bus.branch   = 1'b1;
            bus.pc_write = 1'b1;
            state_d      = S_FETCH;
            retire       = 1'b1;
          end
          C_B: begin
            bus.uncondbranch = 1'b1;
            bus.pc_write     = 1'b1;
            state_d          = S_FETCH;
            retire           = 1'b1;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        bus.alu_src   = 1'b1;
        bus.mem_write = (cls_q == C_STUR);
        bus.mem_read  = (cls_q == C_LDUR);
        if (bus.mem_ready) begin
          // Stores finish here; loads still need the writeback cycle.
          state_d = (cls_q == C_STUR) ? S_FETCH : S_WB;
          retire  = (cls_q == C_STUR);
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        bus.mem2reg   = (cls_q == C_LDUR);
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_DECODE) cls_q <= cls_dec;
      if (state_d == S_ERR)    err_q <= 1'b1;
      if (retire)              cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.state       = state_q;
  assign bus.err         = err_q;
  assign bus.instr_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_legv8_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_legv8_mc_ctrl : directed per-cycle expectations checked by a queue monitor
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_legv8_mc_ctrl;

  localparam logic [13:0] PCW   = 14'h2000;
  localparam logic [13:0] IRW   = 14'h1000;
  localparam logic [13:0] BR    = 14'h0800;
  localparam logic [13:0] UB    = 14'h0400;
  localparam logic [13:0] MR    = 14'h0200;
  localparam logic [13:0] MW    = 14'h0100;
  localparam logic [13:0] RW    = 14'h0080;
  localparam logic [13:0] R2L   = 14'h0040;
  localparam logic [13:0] ASRC  = 14'h0020;
  localparam logic [13:0] M2R   = 14'h0010;
  localparam logic [13:0] AOP_R = 14'h0008;
  localparam logic [13:0] AOP_Z = 14'h0004;
  localparam logic [13:0] ILL   = 14'h0002;
  localparam logic [13:0] ERRB  = 14'h0001;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010111111;
  localparam logic [10:0] OP_BAD  = 11'b00000000000;

  typedef struct packed {
    logic [2:0]  st;
    logic [13:0] ctl;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  logic done;
  int   c;
  int   n_chk;
  int   n_pass;
  exp_t q[$];
  exp_t e;
  logic [13:0] act_ctl;

  legv8_mc_ctrl_if #(.CNTW(16)) bus ();
  legv8_mc_ctrl_if #(.CNTW(4))  bus4 ();

  assign bus4.opcode    = bus.opcode;
  assign bus4.mem_ready = bus.mem_ready;

  legv8_mc_ctrl #(.CNTW(16), .MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  legv8_mc_ctrl #(.CNTW(4), .MEM_TIMEOUT(15)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end

  // One expected record per cycle, sampled by the monitor at the next falling edge.
  task automatic cyc(input logic r, input logic [10:0] op, input logic mr,
                     input logic [2:0] st, input logic [13:0] ctl);
    rst           = r;
    bus.opcode    = op;
    bus.mem_ready = mr;
    q.push_back({st, ctl, 16'(c)});
    @(posedge clk);
    #1;
  endtask

  task automatic rtype(input logic [10:0] op);
    cyc(1'b1, op, 1'b1, 3'd0, MR | IRW | PCW);
    cyc(1'b1, op, 1'b1, 3'd1, 14'h0);
    cyc(1'b1, op, 1'b1, 3'd2, AOP_R);
    cyc(1'b1, op, 1'b1, 3'd4, RW);
    c++;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      act_ctl = {bus.pc_write, bus.ir_write, bus.branch, bus.uncondbranch,
                 bus.mem_read, bus.mem_write, bus.reg_write, bus.reg2loc,
                 bus.alu_src, bus.mem2reg, bus.aluop, bus.illegal, bus.err};
      n_chk++;
      if (bus.state == e.st && act_ctl == e.ctl && bus.instr_count == e.cnt)
        n_pass++;
      else
        $display("FAIL trace t=%0t state/ctl/count got %0d/%h/%0d want %0d/%h/%0d",
                 $time, bus.state, act_ctl, bus.instr_count, e.st, e.ctl, e.cnt);
      n_chk++;
      if (bus4.instr_count == e.cnt[3:0])
        n_pass++;
      else
        $display("FAIL wrap_cnt t=%0t got %0d want %0d",
                 $time, bus4.instr_count, e.cnt[3:0]);
    end else if (done) begin
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  initial begin
    rst           = 1'b0;
    bus.opcode    = OP_ADD;
    bus.mem_ready = 1'b0;
    done          = 1'b0;
    c             = 0;
    n_chk         = 0;
    n_pass        = 0;
    @(posedge clk);
    #1;
    cyc(1'b0, OP_ADD, 1'b0, 3'd0, MR);
    cyc(1'b0, OP_ADD, 1'b0, 3'd0, MR);

    rtype(OP_ADD);
    rtype(OP_SUB);
    rtype(OP_AND);
    rtype(OP_ORR);

    // LDUR with three wait cycles in MEM
    cyc(1'b1, OP_LDUR, 1'b1, 3'd0, MR | IRW | PCW);
    cyc(1'b1, OP_LDUR, 1'b1, 3'd1, 14'h0);
    cyc(1'b1, OP_LDUR, 1'b1, 3'd2, ASRC);
    for (int i = 0; i < 3; i++) cyc(1'b1, OP_LDUR, 1'b0, 3'd3, MR | ASRC);
    cyc(1'b1, OP_LDUR, 1'b1, 3'd3, MR | ASRC);
    cyc(1'b1, OP_LDUR, 1'b1, 3'd4, RW | M2R);
    c++;

    cyc(1'b1, OP_CBZ, 1'b1, 3'd0, MR | IRW | PCW);
    cyc(1'b1, OP_CBZ, 1'b1, 3'd1, R2L);
    cyc(1'b1, OP_CBZ, 1'b1, 3'd2, BR | PCW | R2L | AOP_Z);
    c++;

    cyc(1'b1, OP_B, 1'b1, 3'd0, MR | IRW | PCW);
    cyc(1'b1, OP_B, 1'b1, 3'd1, 14'h0);
    cyc(1'b1, OP_B, 1'b1, 3'd2, UB | PCW);
    c++;

    cyc(1'b1, OP_BAD, 1'b1, 3'd0, MR | IRW | PCW);
    cyc(1'b1, OP_BAD, 1'b1, 3'd1, ILL);

    // STUR with one FETCH wait
    cyc(1'b1, OP_STUR, 1'b0, 3'd0, MR);
    cyc(1'b1, OP_STUR, 1'b1, 3'd0, MR | IRW | PCW);
    cyc(1'b1, OP_STUR, 1'b1, 3'd1, R2L);
    cyc(1'b1, OP_STUR, 1'b1, 3'd2, ASRC);
    cyc(1'b1, OP_STUR, 1'b1, 3'd3, MW | ASRC);
    c++;

    for (int i = 0; i < 16; i++) rtype(OP_ADD);

    // Reset in the middle of a STUR memory wait
    cyc(1'b1, OP_STUR, 1'b1, 3'd0, MR | IRW | PCW);
    cyc(1'b1, OP_STUR, 1'b1, 3'd1, R2L);
    cyc(1'b1, OP_STUR, 1'b1, 3'd2, ASRC);
    cyc(1'b1, OP_STUR, 1'b0, 3'd3, MW | ASRC);
    c = 0;
    cyc(1'b0, OP_STUR, 1'b0, 3'd0, MR);

    // FETCH timeout, then ERR ignores mem_ready until reset
    for (int i = 0; i < 15; i++) cyc(1'b1, OP_ADD, 1'b0, 3'd0, MR);
    cyc(1'b1, OP_ADD, 1'b0, 3'd7, ERRB);
    for (int i = 0; i < 3; i++) cyc(1'b1, OP_ADD, 1'b1, 3'd7, ERRB);
    cyc(1'b0, OP_ADD, 1'b0, 3'd0, MR);
    rtype(OP_ADD);
    cyc(1'b1, OP_ADD, 1'b0, 3'd0, MR);
    done = 1'b1;
  end

endmodule

`default_nettype wire

// File: doc/legv8_mc_ctrl.md
Name: legv8_mc_ctrl

Overview:
- Multi-cycle control sequencer for the LEGv8 datapath.
- Drives the PC_branch unit's branch/uncondbranch inputs and a PC write enable.
- Drives the instruction-register, ALU, memory and register-file control lines.
- Decodes the 11-bit opcode field, steps FETCH→DECODE→EXEC→MEM→WB, and waits on a memory-ready handshake with a timeout.

Parameters:
- CNTW, 16, width of retired-instruction counter (wraps)
- MEM_TIMEOUT, 15, maximum cycles to wait for mem_ready before entering ERR (≥1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- opcode  input  11  instruction bits [31:21] from IR
- mem_ready  input  1  memory access completes this cycle
- pc_write  output  1  PC register load enable
- ir_write  output  1  IR load enable
- branch  output  1  conditional branch (CBZ) to PC_branch
- uncondbranch  output  1  unconditional branch (B) to PC_branch
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- reg_write  output  1  register-file write enable
- reg2loc  output  1  second read register = Rt
- alu_src  output  1  ALU B operand = sign-extended immediate
- mem2reg  output  1  writeback data from memory
- aluop  output  2  00 add, 01 pass-B/zero-test, 10 R-type funct
- state  output  3  current state encoding
- illegal  output  1  one-cycle pulse on undecodable opcode
- err  output  1  sticky memory-timeout flag
- instr_count  output  CNTW  retired instructions

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=7. Only state, class register, wait counter, err and instr_count are flops; all control outputs are combinational from state + latched class.
- Reset (rst=0, async):
  - state=FETCH, class=NONE, wait counter=0, err=0, instr_count=0, illegal=0.
  - Resulting outputs: mem_read=1 (FETCH); all other control outputs 0.
  - A reset mid-access abandons the access; no retire is counted.
- FETCH:
  - mem_read=1.
  - On mem_ready=1: ir_write=1, pc_write=1 (PC+4 path, branch=uncondbranch=0), next state DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE (1 cycle):
  - Classify opcode and latch into class. Decode priority:
    - B: opcode[10:5]=000101
    - CBZ: opcode[10:3]=10110100
    - LDUR: 11111000010
    - STUR: 11111000000
    - ADD: 10001011000
    - SUB: 11001011000
    - AND: 10001010000
    - ORR: 10101010000
  - reg2loc=1 for STUR, CBZ.
  - Unknown opcode: illegal=1 this cycle, next state FETCH, not retired. Otherwise next state EXEC.
- EXEC (1 cycle):
  - R-type: aluop=10, alu_src=0 → WB.
  - LDUR/STUR: aluop=00, alu_src=1 → MEM.
  - CBZ: aluop=01, reg2loc=1, branch=1, pc_write=1 → FETCH, retire. PC_branch resolves taken/not-taken via flagz.
  - B: uncondbranch=1, pc_write=1 → FETCH, retire.
- MEM:
  - alu_src=1, aluop=00.
  - LDUR: mem_read=1; on mem_ready → WB.
  - STUR: mem_write=1; on mem_ready → FETCH, retire.
- WB (1 cycle):
  - reg_write=1; mem2reg=1 iff LDUR.
  - → FETCH, retire.
- Retire: instr_count+1 on the clock edge leaving the final state of an instruction; wraps 2^CNTW−1→0.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and on mem_ready.
  - Wait counter increments each cycle spent waiting in FETCH or MEM.
  - If it reaches MEM_TIMEOUT with mem_ready still 0: next state ERR, err=1.
- ERR:
  - All strobes 0; stays in ERR until reset. mem_ready is ignored.
- mem_ready outside FETCH/MEM is ignored.
- Zero-wait memory (mem_ready held high) latencies:
  - R-type and LDUR: 4 and 5 cycles.
  - STUR: 4 cycles.
  - B and CBZ: 3 cycles.

Test Plan:
- Reset, mem_ready=1, opcode=10001011000 (ADD) → states 0,1,2,4,0; aluop=10 in EXEC; reg_write=1 in WB; instr_count=1 after 4 cycles.
- LDUR 11111000010, mem_ready low for 3 cycles in MEM → mem_read held 4 cycles; WB shows mem2reg=1, reg_write=1; count+1.
- CBZ 10110100xxx → EXEC shows branch=1, pc_write=1, reg2loc=1, aluop=01; uncondbranch=0. Then B 000101xxxxx → uncondbranch=1, branch=0; 3 cycles each.
- Opcode 00000000000 → illegal pulses 1 cycle in DECODE; returns to FETCH; count unchanged.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 → state=7 and err=1 after 15 cycles. Later mem_ready=1 has no effect; rst low clears to FETCH with err=0.
- rst asserted mid-MEM of STUR → immediate FETCH, mem_write=0, count unchanged. CNTW=4 with 16 ADDs → count wraps to 0.
